// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared types for the instruction cache
package cpu_types_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } icache_state_t;

  // Fetch address layout for the default 16-set, 2-word geometry
  typedef struct packed {
    logic [24:0] tag;
    logic [3:0]  idx;
    logic [0:0]  blkoff;
    logic [1:0]  bytoff;
  } icache_addr_t;

endpackage

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped instruction cache with word-serial block fill
module icache
  import cpu_types_pkg::*;
#(
  parameter int SETS        = 16,
  parameter int BLOCK_WORDS = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic [31:0] imemload,
  output logic        ihit,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic [31:0] iload,
  input  logic        iwait
);

  localparam int IB = $clog2(SETS);
  localparam int OB = $clog2(BLOCK_WORDS);
  localparam int CW = (OB > 0) ? OB : 1;
  localparam int TW = 30 - IB - OB;

  icache_state_t   state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [TW-1:0]   fill_tag;
  logic [IB-1:0]   fill_idx;
  logic [SETS-1:0] valid;
  logic [TW-1:0]   tags [SETS];
  logic [31:0]     data [SETS][BLOCK_WORDS];

  logic [TW-1:0] req_tag;
  logic [IB-1:0] req_idx;
  logic [CW-1:0] req_word;
  logic          lookup_hit;
  logic          last_word;
  logic          word_done;
  logic          miss_start;
  logic          unused_bytoff;

  assign req_tag       = imemaddr[31:IB+OB+2];
  assign req_idx       = imemaddr[IB+OB+1:OB+2];
  assign req_word      = CW'(imemaddr[31:2] & 30'(BLOCK_WORDS - 1));
  assign unused_bytoff = ^imemaddr[1:0];

  assign lookup_hit = valid[req_idx] && (tags[req_idx] == req_tag);
  assign last_word  = (cnt == CW'(BLOCK_WORDS - 1));
  assign word_done  = (state == FILL) && !iwait;
  assign miss_start = (state == IDLE) && imemREN && !lookup_hit;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ihit      = 1'b0;
    imemload  = 32'h0;
    iREN      = 1'b0;
    iaddr     = 32'h0;
    case (state)
      IDLE: begin
        ihit = imemREN && lookup_hit;
        if (ihit) imemload = data[req_idx][req_word];
        if (miss_start) begin
          state_nxt = FILL;
          cnt_nxt   = '0;
        end
      end
      FILL: begin
        iREN  = 1'b1;
        iaddr = (32'({fill_tag, fill_idx}) << (OB + 2)) | (32'(cnt) << 2);
        if (!iwait) begin
          // Compare before incrementing so the counter never spills into the index
          if (last_word) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      cnt      <= '0;
      fill_tag <= '0;
      fill_idx <= '0;
      valid    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (miss_start) begin
        fill_tag         <= req_tag;
        fill_idx         <= req_idx;
        // Victim is invalidated up front so an interrupted fill is never trusted
        valid[req_idx]   <= 1'b0;
      end
      if (word_done && last_word) valid[fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (word_done) data[fill_idx][cnt] <= iload;
    if (word_done && last_word) tags[fill_idx] <= fill_tag;
  end

endmodule
